rom_loader: RTL

Download sequencer between the HPS ROM-download port and the Crazy Kong core. Decodes the linear `ioctl` byte stream into five ROM regions with one-hot write strobes and region-relative addresses, and keeps a running byte count and checksum. Holds the core in reset while loading and for a settle period after it. Releases the core only after a complete, gap-free load of exactly the expected size.

---
 rtl/rom_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Splits the HPS ROM-download byte stream into five ROM regions for the Crazy Kong core.
// Holds the core in reset while loading and until a settle delay after a clean, complete load.
module rom_loader #(
  parameter logic [16:0] CPU_END     = 17'h06000,
  parameter logic [16:0] TILE_END    = 17'h08000,
  parameter logic [16:0] SPR_END     = 17'h0A000,
  parameter logic [16:0] PROM_END    = 17'h0A040,
  parameter logic [16:0] TOTAL       = 17'h0C040,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [4:0]  dn_we,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  // state    | meaning
  // S_IDLE   | no image loaded since reset, core held in reset
  // S_LOAD   | download active, bytes checked and routed to regions
  // S_SETTLE | clean load finished, core held while hold counter runs down
  // S_RUN    | core released, only ext_reset can assert core_reset
  // S_ERROR  | last load bad, core held in reset until the next download
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_ERROR} state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);

  state_t      r_state, w_next;
  logic        r_dl_prev, r_fall_pend, r_err;
  logic [7:0]  r_hold;
  logic [16:0] r_dn_addr, r_byte_count;
  logic [7:0]  r_dn_data, r_checksum;
  logic [4:0]  r_dn_we;
  logic        r_core_reset, r_load_ok, r_load_err;

  logic        w_rise, w_fall, w_wr_load, w_range_bad, w_order_bad, w_accept;
  logic [16:0] w_rel, w_base, w_off;
  logic [4:0]  w_we_sel;

  assign w_rise      = ioctl_download & ~r_dl_prev;
  assign w_fall      = ~ioctl_download & r_dl_prev;
  assign w_rel       = ioctl_addr[16:0];
  assign w_wr_load   = (r_state == S_LOAD) && ioctl_wr && !r_fall_pend && !w_rise;
  assign w_range_bad = (ioctl_addr[24:17] != 8'd0) || (w_rel >= TOTAL);
  assign w_order_bad = (w_rel != r_byte_count);
  assign w_accept    = w_wr_load && !w_range_bad && !w_order_bad;
  assign w_off       = w_rel - w_base;

  always_comb begin
    w_we_sel = 5'b00000;
    w_base   = 17'd0;
    if (w_rel < CPU_END) begin
      w_we_sel = 5'b00001;
    end else if (w_rel < TILE_END) begin
      w_we_sel = 5'b00010;
      w_base   = CPU_END;
    end else if (w_rel < SPR_END) begin
      w_we_sel = 5'b00100;
      w_base   = TILE_END;
    end else if (w_rel < PROM_END) begin
      w_we_sel = 5'b01000;
      w_base   = SPR_END;
    end else begin
      w_we_sel = 5'b10000;
      w_base   = PROM_END;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_rise) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        // exit is decided one cycle after the fall so a final same-cycle byte is counted
        S_LOAD:   if (r_fall_pend) w_next = (r_err || r_byte_count != TOTAL) ? S_ERROR : S_SETTLE;
        S_SETTLE: if (r_hold <= 8'd1) w_next = S_RUN;
        default:  w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      // track the level through reset so a download still high afterwards is not seen as a new start
      r_dl_prev    <= ioctl_download;
      r_fall_pend  <= 1'b0;
      r_err        <= 1'b0;
      r_hold       <= 8'd0;
      r_dn_addr    <= 17'd0;
      r_dn_data    <= 8'd0;
      r_dn_we      <= 5'd0;
      r_byte_count <= 17'd0;
      r_checksum   <= 8'd0;
      r_core_reset <= 1'b1;
      r_load_ok    <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_dn_we   <= 5'd0;
      if (w_rise) begin
        r_fall_pend  <= 1'b0;
        r_err        <= 1'b0;
        r_hold       <= 8'd0;
        r_byte_count <= 17'd0;
        r_checksum   <= 8'd0;
        r_core_reset <= 1'b1;
        r_load_ok    <= 1'b0;
        r_load_err   <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_core_reset <= 1'b1;
            if (w_accept) begin
              r_dn_we      <= w_we_sel;
              r_dn_addr    <= w_off;
              r_dn_data    <= ioctl_dout;
              r_byte_count <= r_byte_count + 17'd1;
              r_checksum   <= r_checksum + ioctl_dout;
            end else if (w_wr_load) begin
              r_err <= 1'b1;
            end
            if (w_fall) r_fall_pend <= 1'b1;
            if (r_fall_pend) begin
              r_fall_pend <= 1'b0;
              if (w_next == S_SETTLE) r_hold     <= HOLD_LD;
              else                    r_load_err <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (w_next == S_RUN) begin
              r_hold       <= 8'd0;
              r_load_ok    <= 1'b1;
              r_core_reset <= ext_reset;
            end else begin
              r_hold       <= r_hold - 8'd1;
              r_core_reset <= 1'b1;
            end
          end
          S_RUN:   r_core_reset <= ext_reset;
          default: r_core_reset <= 1'b1;
        endcase
      end
    end
  end

  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_we      = r_dn_we;
  assign core_reset = r_core_reset;
  assign load_ok    = r_load_ok;
  assign load_err   = r_load_err;
  assign byte_count = r_byte_count;
  assign checksum   = r_checksum;

endmodule
